// File: rtl/trng_autocorr_if.sv
// Serial entropy bit stream handshake between the TRNG source and the autocorrelation engine.
interface trng_autocorr_if;
  logic bit_in;
  logic bit_valid;
  logic bit_ready;

  modport master (output bit_in, output bit_valid, input bit_ready);
  modport slave  (input bit_in, input bit_valid, output bit_ready);
endinterface

// File: rtl/trng_autocorr_engine.sv
// Autocorrelation health test: counts bit agreements at lags 1..NUM_LAGS over a block,
// scores each count through an external PMF table and tracks consecutive failing blocks.
module trng_autocorr_engine #(
  parameter int BLOCK_BITS = 184,
  parameter int NUM_LAGS   = 4,
  parameter int CNT_W      = 8,
  parameter int FAIL_LIMIT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  trng_autocorr_if.slave      bit_if,
  input  logic [13:0]         pmf_thresh,
  output logic [CNT_W-1:0]    pmf_addr,
  input  logic [13:0]         pmf_data,
  input  logic                err_clr,
  output logic                block_done,
  output logic                block_fail,
  output logic [NUM_LAGS-1:0] fail_lags,
  output logic [3:0]          consec_fail,
  output logic                autocorr_err
);
  localparam int IDX_W = (NUM_LAGS > 1) ? $clog2(NUM_LAGS) : 1;

  typedef enum logic [2:0] {IDLE, PRIME, COLLECT, EVAL, REPORT} state_e;

  state_e              state_q, state_d;
  logic [NUM_LAGS-1:0] hist_q, hist_d;
  logic [NUM_LAGS-1:0] mask_q, mask_d;
  logic [NUM_LAGS-1:0] fail_lags_q, fail_lags_d;
  logic [CNT_W-1:0]    cnt_q [NUM_LAGS];
  logic [CNT_W-1:0]    cnt_d [NUM_LAGS];
  logic [IDX_W-1:0]    prime_q, prime_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [3:0]          consec_q, consec_d;
  logic                err_q, err_d;
  logic                take;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (v >= CNT_W'(BLOCK_BITS)) ? v : v + CNT_W'(1);
  endfunction

  // hist[0] is the newest bit, hist[k-1] is the bit k positions back.
  function automatic logic [NUM_LAGS-1:0] shift_in(input logic [NUM_LAGS-1:0] h, input logic b);
    logic [NUM_LAGS-1:0] r;
    r    = h << 1;
    r[0] = b;
    return r;
  endfunction

  assign bit_if.bit_ready = enable & ((state_q == PRIME) || (state_q == COLLECT));
  assign take             = bit_if.bit_valid & bit_if.bit_ready;
  assign pmf_addr         = (state_q == EVAL) ? cnt_q[idx_q] : '0;
  assign block_done       = enable & (state_q == REPORT);
  assign block_fail       = block_done & (|mask_q);
  assign fail_lags        = fail_lags_q;
  assign consec_fail      = consec_q;
  assign autocorr_err     = err_q;

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    mask_d      = mask_q;
    fail_lags_d = fail_lags_q;
    cnt_d       = cnt_q;
    prime_d     = prime_q;
    idx_d       = idx_q;
    bitcnt_d    = bitcnt_q;
    consec_d    = consec_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        hist_d   = '0;
        mask_d   = '0;
        prime_d  = '0;
        idx_d    = '0;
        bitcnt_d = '0;
        for (int i = 0; i < NUM_LAGS; i++) cnt_d[i] = '0;
        if (enable) state_d = PRIME;
      end
      PRIME: begin
        if (take) begin
          hist_d = shift_in(hist_q, bit_if.bit_in);
          if (prime_q == IDX_W'(NUM_LAGS - 1)) begin
            prime_d = '0;
            state_d = COLLECT;
          end else begin
            prime_d = prime_q + IDX_W'(1);
          end
        end
      end
      COLLECT: begin
        if (take) begin
          for (int i = 0; i < NUM_LAGS; i++)
            if (bit_if.bit_in == hist_q[i]) cnt_d[i] = sat_cnt(cnt_q[i]);
          hist_d = shift_in(hist_q, bit_if.bit_in);
          if (bitcnt_q == CNT_W'(BLOCK_BITS - 1)) begin
            bitcnt_d = '0;
            idx_d    = '0;
            state_d  = EVAL;
          end else begin
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end
        end
      end
      EVAL: begin
        mask_d[idx_q] = (pmf_data < pmf_thresh);
        if (idx_q == IDX_W'(NUM_LAGS - 1)) begin
          fail_lags_d = mask_d;
          idx_d       = '0;
          state_d     = REPORT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      REPORT: begin
        consec_d = (|mask_q) ? sat_inc4(consec_q) : 4'd0;
        if (consec_d >= 4'(FAIL_LIMIT)) err_d = 1'b1;
        for (int i = 0; i < NUM_LAGS; i++) cnt_d[i] = '0;
        mask_d  = '0;
        state_d = COLLECT;
      end
      default: state_d = IDLE;
    endcase

    // Disabling abandons the block in flight but keeps the reported status.
    if (!enable) begin
      state_d     = IDLE;
      fail_lags_d = fail_lags_q;
      consec_d    = consec_q;
      err_d       = err_q;
    end
    if (err_clr) begin
      consec_d = '0;
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hist_q      <= '0;
      mask_q      <= '0;
      fail_lags_q <= '0;
      for (int i = 0; i < NUM_LAGS; i++) cnt_q[i] <= '0;
      prime_q     <= '0;
      idx_q       <= '0;
      bitcnt_q    <= '0;
      consec_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      mask_q      <= mask_d;
      fail_lags_q <= fail_lags_d;
      cnt_q       <= cnt_d;
      prime_q     <= prime_d;
      idx_q       <= idx_d;
      bitcnt_q    <= bitcnt_d;
      consec_q    <= consec_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: doc/trng_autocorr_engine.md
Name: trng_autocorr_engine

Overview:
- Parametrised autocorrelation health-test engine for the TRNG test path.
- Consumes the raw serial entropy bit stream and counts bit agreements over a fixed block for NUM_LAGS lags.
- Scores each lag through the external PMF table, which stays combinational and sits outside this block.
- Flags failing blocks and raises a sticky error after FAIL_LIMIT consecutive failing blocks.

Parameters:
- BLOCK_BITS, 184: comparisons per lag per block; also the PMF table domain.
- NUM_LAGS, 4: number of lags tested (lags 1..NUM_LAGS); range 1..8.
- CNT_W, 8: agreement counter width; must satisfy 2^CNT_W > BLOCK_BITS.
- FAIL_LIMIT, 3: consecutive failing blocks that set autocorr_err; range 1..15.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  test enable; 0 forces IDLE
- bit_in  in  1  raw entropy bit
- bit_valid  in  1  bit_in is valid
- bit_ready  out  1  engine accepts a bit this cycle
- pmf_thresh  in  14  minimum acceptable PMF score, quasi-static
- pmf_addr  out  CNT_W  agreement count presented to the PMF table
- pmf_data  in  14  PMF score returned combinationally, same cycle
- err_clr  in  1  clears autocorr_err and consec_fail
- block_done  out  1  one-cycle pulse at block evaluation end
- block_fail  out  1  valid with block_done; any lag failed
- fail_lags  out  NUM_LAGS  per-lag fail mask, held until next block_done
- consec_fail  out  4  consecutive failing block count, saturating
- autocorr_err  out  1  sticky error

Behaviour:
- Clock/reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: all outputs 0; FSM = IDLE; history, counters and mask cleared.
- Handshake:
  - A bit transfers when bit_valid & bit_ready.
  - bit_ready = 1 only in PRIME and COLLECT.
- FSM: IDLE -> PRIME -> COLLECT -> EVAL -> REPORT -> COLLECT.
- IDLE:
  - Exit to PRIME when enable = 1.
  - Clears history, agreement counters, prime count and bit count.
- PRIME:
  - Accepts NUM_LAGS bits into the history shift register; no counting.
  - After NUM_LAGS transfers, go to COLLECT.
- COLLECT, per transferred bit b:
  - For every lag k, cnt[k] increments when b == hist[k-1].
  - hist shifts with b entering at hist[0].
  - After exactly BLOCK_BITS transfers, go to EVAL.
  - Each cnt is 0..BLOCK_BITS and never wraps.
- EVAL:
  - Lasts NUM_LAGS cycles; cycle j drives pmf_addr = cnt[j+1].
  - fail bit j = (pmf_data < pmf_thresh), sampled that cycle.
  - pmf_addr is 0 outside EVAL.
- REPORT:
  - One cycle: block_done = 1; block_fail = |mask; fail_lags updated.
  - If block_fail, consec_fail increments, saturating at 15; else consec_fail clears to 0.
  - autocorr_err sets when the consec_fail next value >= FAIL_LIMIT.
  - Counters clear; go to COLLECT.
  - History is retained, so no re-prime is needed.
- Latency: last COLLECT transfer to block_done pulse = NUM_LAGS + 1 cycles.
- enable deasserted in any state:
  - Next state is IDLE; the partial block is discarded; no block_done.
  - autocorr_err, consec_fail and fail_lags are held.
  - Re-enable re-primes.
- err_clr:
  - Clears autocorr_err and consec_fail.
  - If it coincides with a REPORT, err_clr wins: both are 0 afterwards.
- bit_valid outside PRIME/COLLECT is ignored; there is no buffering.

Test Plan:
- All-ones stream, NUM_LAGS=4, BLOCK_BITS=184; table stub returns 0 at addr 184 and pmf_thresh=1 -> pmf_addr=184 on all 4 EVAL cycles; block_done with fail_lags=4'b1111.
- Alternating 1010... stream -> pmf_addr sequence 0,184,0,184; with the stub scoring 0 at ends -> block_fail=1, consec_fail=1.
- Random stream, stub returns 10793 everywhere, pmf_thresh=100 -> block_fail=0, consec_fail=0; block_done exactly 5 cycles after the 184th COLLECT bit; 4 bits consumed before the first block.
- Three consecutive all-ones blocks, FAIL_LIMIT=3 -> autocorr_err rises at the third REPORT; err_clr pulse -> autocorr_err=0, consec_fail=0.
- Drop enable after 100 COLLECT bits, re-enable -> no block_done; bit_ready low one cycle in IDLE; PRIME consumes 4 bits; next block_done after 184 further bits.
- Hold bit_valid=1 through EVAL/REPORT -> bit_ready=0 those 5 cycles and counts are unaffected (checked by scoreboard).
